// File: rtl/uart_rx_deframe_if.sv
// Link between the start-bit detector side and the UART receive deframer.
// Handshake: receive_enable rises when a start edge is detected and must stay
// high until char_received is seen. char_received is a one-cycle pulse that
// closes every frame attempt. data_valid/frame_error qualify it; neither waits
// on a ready, so the consumer must capture data_out on the data_valid cycle.
interface uart_rx_deframe_if #(
  parameter int DATA_BITS = 8
);
  logic                 receive_enable;
  logic                 data_in;
  logic                 char_received;
  logic [DATA_BITS-1:0] data_out;
  logic                 data_valid;
  logic                 frame_error;
  logic                 busy;

  modport master (
    output receive_enable, data_in,
    input  char_received, data_out, data_valid, frame_error, busy
  );

  modport slave (
    input  receive_enable, data_in,
    output char_received, data_out, data_valid, frame_error, busy
  );
endinterface

// File: rtl/uart_rx_deframe.sv
// UART receive deframer: mid-bit start re-check, LSB-first data sampling at bit
// centres, stop-bit check, and single-cycle completion strobes.
module uart_rx_deframe #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  uart_rx_deframe_if.slave     link,
  output logic [2:0]           fsm_state
);
  localparam int CNT_W = $clog2(OVERSAMPLE);
  localparam int IDX_W = $clog2(DATA_BITS + 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(OVERSAMPLE - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t               st;
  logic [CNT_W-1:0]     cnt;
  logic [IDX_W-1:0]     bit_idx;
  logic [DATA_BITS-1:0] shreg;

  assign fsm_state = st;

  always_ff @(posedge clk) begin
    if (!reset) begin
      st                 <= IDLE;
      cnt                <= '0;
      bit_idx            <= '0;
      shreg              <= '0;
      link.data_out      <= '0;
      link.char_received <= 1'b0;
      link.data_valid    <= 1'b0;
      link.frame_error   <= 1'b0;
      link.busy          <= 1'b0;
    end else begin
      link.char_received <= 1'b0;
      link.data_valid    <= 1'b0;
      link.frame_error   <= 1'b0;
      case (st)
        IDLE: begin
          if (link.receive_enable) begin
            st        <= START;
            cnt       <= '0;
            link.busy <= 1'b1;
          end
        end
        START: begin
          // A dropped enable means the detector was reset: abandon silently.
          if (!link.receive_enable) begin
            st        <= IDLE;
            cnt       <= '0;
            link.busy <= 1'b0;
          end else if (cnt == HALF_LAST) begin
            cnt <= '0;
            if (link.data_in) begin
              st                 <= DONE;
              link.char_received <= 1'b1;
              link.frame_error   <= 1'b1;
            end else begin
              st      <= DATA;
              bit_idx <= '0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (!link.receive_enable) begin
            st        <= IDLE;
            cnt       <= '0;
            link.busy <= 1'b0;
          end else if (cnt == BIT_LAST) begin
            shreg   <= {link.data_in, shreg[DATA_BITS-1:1]};
            bit_idx <= bit_idx + 1'b1;
            cnt     <= '0;
            if (bit_idx == IDX_LAST) st <= STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          if (!link.receive_enable) begin
            st        <= IDLE;
            cnt       <= '0;
            link.busy <= 1'b0;
          end else if (cnt == BIT_LAST) begin
            st                 <= DONE;
            cnt                <= '0;
            link.char_received <= 1'b1;
            if (link.data_in) begin
              link.data_valid <= 1'b1;
              link.data_out   <= shreg;
            end else begin
              link.frame_error <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          // Strobes were raised on entry; the detector drops enable mid-cycle.
          st        <= IDLE;
          link.busy <= 1'b0;
        end
        default: begin
          st        <= IDLE;
          cnt       <= '0;
          link.busy <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_uart_rx_deframe.sv
// Bench for uart_rx_deframe: a cycle-indexed serial waveform drives the DUT through
// a start-edge detector model; expected strobes come from the frame sampling rules.
module tb_uart_rx_deframe;
  localparam int DB   = 8;
  localparam int OS   = 16;
  localparam int B    = 20;
  localparam int MAXC = 6000;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [2:0] fsm_state;

  uart_rx_deframe_if #(.DATA_BITS(DB)) link();

  uart_rx_deframe #(.DATA_BITS(DB), .OVERSAMPLE(OS)) dut (
    .clk       (clk),
    .reset     (reset),
    .link      (link),
    .fsm_state (fsm_state)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  bit            line_at [MAXC];
  bit            abort_at[MAXC];
  bit            exp_busy[MAXC];
  bit            exp_cr  [MAXC];
  bit            exp_dv  [MAXC];
  bit            exp_fe  [MAXC];
  bit            exp_dset[MAXC];
  logic [DB-1:0] exp_dval[MAXC];
  logic [DB-1:0] exp_q[$];

  int   wp = 0;
  int   end_c = MAXC - 1;
  int   total = 0;
  int   bad = 0;
  logic man_re = 1'b1;
  logic man_line = 1'b1;
  bit   det_on = 1'b0;
  logic prev_line = 1'b1;
  logic [DB-1:0] cur_dout = '0;
  int   p_good, p_fs, p_bad, p_b2b, p_tmp, p_ab;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, got, exp);
    end
  endtask

  task automatic goto(input int n);
    if (cyc >= n) begin
      chk("goto_order", 32'(cyc), 32'(n - 1));
    end else begin
      while (cyc < n) @(negedge clk);
      #1;
    end
  endtask

  // ---------------- stimulus waveform builders ----------------
  task automatic put(input bit v, input int n);
    for (int i = 0; i < n; i++) begin
      line_at[wp] = v;
      wp++;
    end
  endtask

  task automatic frame(input logic [DB-1:0] d, input bit stop, output int p);
    p = wp;
    put(1'b0, OS);
    for (int i = 0; i < DB; i++) put(d[i], OS);
    put(stop, OS);
  endtask

  // ---------------- behavioural model ----------------
  task automatic run_model();
    int c, free_from, e0, ed, ab;
    bit good;
    logic [DB-1:0] d;
    c = B + 1;
    free_from = B + 1;
    while (c < end_c) begin
      if (c >= free_from && line_at[c-1] && !line_at[c] && !abort_at[c]) begin
        e0 = c + 1;
        good = 1'b0;
        d = '0;
        if (line_at[e0 + OS/2 - 1]) begin
          ed = e0 + OS/2;
        end else begin
          for (int i = 0; i < DB; i++) d[i] = line_at[e0 + OS/2 - 1 + OS*(i+1)];
          good = line_at[e0 + OS/2 - 1 + OS*(DB+1)];
          ed = e0 + OS/2 + OS*(DB+1);
        end
        ab = -1;
        for (int a = e0; a < ed; a++) if (abort_at[a] && ab < 0) ab = a;
        if (ab >= 0) begin
          for (int k = e0; k <= ab; k++) exp_busy[k] = 1'b1;
          c = ab + 1;
        end else begin
          for (int k = e0; k <= ed; k++) exp_busy[k] = 1'b1;
          exp_cr[ed] = 1'b1;
          if (good) begin
            exp_dv[ed]   = 1'b1;
            exp_dset[ed] = 1'b1;
            exp_dval[ed] = d;
            exp_q.push_back(d);
          end else begin
            exp_fe[ed] = 1'b1;
          end
          c = ed + 1;
        end
        free_from = c;
      end else begin
        c++;
      end
    end
  endtask

  // ---------------- line driver ----------------
  initial begin
    link.data_in = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      link.data_in = (cyc >= B && cyc < end_c) ? line_at[cyc] : ((cyc < B) ? man_line : 1'b1);
    end
  end

  // ---------------- start-edge detector (falling-edge updates) ----------------
  initial begin
    link.receive_enable = 1'b0;
    forever begin
      @(negedge clk);
      if (!det_on) link.receive_enable = man_re;
      else if (link.char_received || abort_at[cyc]) link.receive_enable = 1'b0;
      else if (!link.receive_enable && prev_line && !link.data_in) link.receive_enable = 1'b1;
      prev_line = link.data_in;
    end
  end

  // ---------------- per-cycle compare and scoreboard ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (cyc >= B && cyc < end_c) begin
        if (exp_dset[cyc]) cur_dout = exp_dval[cyc];
        chk("busy",          32'(link.busy),          32'(exp_busy[cyc]));
        chk("char_received", 32'(link.char_received), 32'(exp_cr[cyc]));
        chk("data_valid",    32'(link.data_valid),    32'(exp_dv[cyc]));
        chk("frame_error",   32'(link.frame_error),   32'(exp_fe[cyc]));
        chk("data_out",      32'(link.data_out),      32'(cur_dout));
        if (link.data_valid) begin
          if (exp_q.size() == 0) chk("sb_extra_char", 32'(link.data_out), 32'hFFFF_FFFF);
          else chk("sb_char", 32'(link.data_out), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  initial begin
    #(MAXC * 20);
    $display("FAIL watchdog: bench did not finish by cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [DB-1:0] rb;
    int kind, gap, j, off, idx;
    bit stop;

    wp = B;
    put(1'b1, 20);
    frame(8'hA5, 1'b1, p_good);  put(1'b1, 30);
    p_fs = wp;  put(1'b0, 3);  put(1'b1, 40);
    frame(8'h3C, 1'b0, p_bad);   put(1'b1, 30);
    frame(8'h00, 1'b1, p_b2b);   frame(8'hFF, 1'b1, p_tmp);  put(1'b1, 30);
    frame(8'hFF, 1'b1, p_ab);    abort_at[p_ab + 60] = 1'b1;  put(1'b1, 40);
    for (int n = 0; n < 10; n++) begin
      rb = DB'($urandom_range(0, 255));
      kind = $urandom_range(0, 9);
      if (kind == 0) begin
        put(1'b0, $urandom_range(1, 5));
        put(1'b1, $urandom_range(10, 40));
      end else begin
        stop = (kind != 1);
        frame(rb, stop, p_tmp);
        if (kind >= 7) begin
          // One-cycle glitch inside a data bit, away from its centre sample.
          j = $urandom_range(0, DB - 1);
          off = $urandom_range(0, OS - 1);
          if (off == OS/2) off = 3;
          idx = p_tmp + OS*(j+1) + off;
          line_at[idx] = ~line_at[idx];
        end
        gap = stop ? $urandom_range(0, 40) : $urandom_range(1, 40);
        put(1'b1, gap);
      end
    end
    put(1'b1, 300);
    end_c = wp;
    run_model();

    // Hand-derived pins on the model's own predictions.
    chk("pin_a5_dv",    32'(exp_dv[p_good + 153]),     32'd1);
    chk("pin_a5_val",   32'(exp_dval[p_good + 153]),   32'hA5);
    chk("pin_fs_fe",    32'(exp_fe[p_fs + 9]),         32'd1);
    chk("pin_bad_fe",   32'(exp_fe[p_bad + 153]),      32'd1);
    chk("pin_b2b_0",    32'(exp_dval[p_b2b + 153]),    32'h00);
    chk("pin_b2b_1",    32'(exp_dval[p_b2b + 313]),    32'hFF);
    chk("pin_ab_busy1", 32'(exp_busy[p_ab + 60]),      32'd1);
    chk("pin_ab_busy0", 32'(exp_busy[p_ab + 61]),      32'd0);

    // Reset held with enable high and a toggling line.
    for (int k = 1; k <= 3; k++) begin
      goto(k);
      chk("rst_state", 32'(fsm_state),          32'd0);
      chk("rst_busy",  32'(link.busy),          32'd0);
      chk("rst_cr",    32'(link.char_received), 32'd0);
      chk("rst_dv",    32'(link.data_valid),    32'd0);
      chk("rst_fe",    32'(link.frame_error),   32'd0);
      chk("rst_dout",  32'(link.data_out),      32'd0);
      man_line = ~man_line;
    end
    man_line = 1'b1;
    reset = 1'b1;
    goto(4);
    chk("rel_busy",    32'(link.busy), 32'd1);
    chk("rel_nonidle", 32'(fsm_state != 3'd0), 32'd1);
    man_re = 1'b0;
    goto(5);
    chk("rel_busy_hold", 32'(link.busy), 32'd1);
    goto(6);
    chk("rel_abort_busy", 32'(link.busy),          32'd0);
    chk("rel_abort_cr",   32'(link.char_received), 32'd0);
    chk("rel_abort_fe",   32'(link.frame_error),   32'd0);
    goto(7);
    det_on = 1'b1;

    goto(p_good + 153);
    chk("good_cr",   32'(link.char_received), 32'd1);
    chk("good_dv",   32'(link.data_valid),    32'd1);
    chk("good_dout", 32'(link.data_out),      32'hA5);
    chk("good_fe",   32'(link.frame_error),   32'd0);
    goto(p_good + 154);
    chk("good_re_fell", 32'(link.receive_enable), 32'd0);
    chk("good_cr_end",  32'(link.char_received),  32'd0);
    chk("good_idle",    32'(link.busy),           32'd0);

    goto(p_fs + 9);
    chk("fs_cr",   32'(link.char_received), 32'd1);
    chk("fs_fe",   32'(link.frame_error),   32'd1);
    chk("fs_dv",   32'(link.data_valid),    32'd0);
    chk("fs_dout", 32'(link.data_out),      32'hA5);

    goto(p_bad + 153);
    chk("bad_fe",   32'(link.frame_error), 32'd1);
    chk("bad_dv",   32'(link.data_valid),  32'd0);
    chk("bad_dout", 32'(link.data_out),    32'hA5);

    goto(p_b2b + 153);
    chk("b2b0_dv",   32'(link.data_valid), 32'd1);
    chk("b2b0_dout", 32'(link.data_out),   32'h00);
    goto(p_b2b + 313);
    chk("b2b1_dv",   32'(link.data_valid), 32'd1);
    chk("b2b1_dout", 32'(link.data_out),   32'hFF);

    goto(p_ab + 62);
    chk("abort_busy", 32'(link.busy),     32'd0);
    chk("abort_dout", 32'(link.data_out), 32'hFF);

    goto(end_c + 1);
    chk("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/uart_rx_deframe.md
Name: uart_rx_deframe

Overview:
- Receive-side deframer that sits directly downstream of the start-bit detector (sb_detect) in the serial link to the game controller.
- Once the detector raises receive_enable, this block:
  - re-checks the start bit at mid-bit;
  - samples the data bits LSB first at bit centres;
  - checks the stop bit;
  - pulses char_received for one cycle so the detector re-arms.
- Good characters are presented on data_out with a one-cycle data_valid strobe for the game-logic FSM.

Parameters:
- DATA_BITS, 8, number of data bits per frame, LSB first.
- OVERSAMPLE, 16, clk cycles per serial bit; must be even and ≥ 4.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-low reset; reset==0 at a rising clk edge clears the block.
- receive_enable  input  1  from sb_detect; high from start-bit detection until char_received is seen.
- data_in  input  1  serial line, idle high, same line sb_detect watches.
- char_received  output  1  one-cycle pulse at the end of every frame attempt, good or bad; releases sb_detect.
- data_out  output  DATA_BITS  last correctly received character; holds until the next good frame.
- data_valid  output  1  one-cycle pulse, coincident with char_received, only for a good frame.
- frame_error  output  1  one-cycle pulse, coincident with char_received, for a false start or a bad stop bit.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- All outputs are registered.
- Reset (reset==0 at a posedge): state=IDLE; cnt=0; bit_idx=0; shift register=0. Outputs: data_out=0, char_received=0, data_valid=0, frame_error=0, busy=0. Reset overrides everything, including mid-frame.
- Counters: cnt is clog2(OVERSAMPLE) bits wide; bit_idx is clog2(DATA_BITS+1) bits wide.
- IDLE:
  - receive_enable==1 → START with cnt=0.
  - Otherwise stay in IDLE.
- START:
  - cnt increments each cycle.
  - When cnt==OVERSAMPLE/2-1, sample data_in:
    - 0 → DATA with cnt=0, bit_idx=0.
    - 1 (false start) → DONE with error flag set.
- DATA:
  - cnt increments each cycle, 0..OVERSAMPLE-1.
  - When cnt==OVERSAMPLE-1: shift right, data_in enters the MSB; bit_idx++; cnt=0.
  - After the DATA_BITS-th sample → STOP.
- STOP:
  - When cnt==OVERSAMPLE-1, sample data_in: 1 → good frame, 0 → error flag set.
  - Go to DONE.
- DONE (exactly one cycle):
  - char_received=1.
  - Good frame: data_out ← shift register, data_valid=1.
  - Error: frame_error=1, data_out unchanged.
  - Next state IDLE.
- Handshake with sb_detect:
  - The detector updates on the falling edge. The DONE cycle spans one falling edge, so the detector clears receive_enable before the next rising edge.
  - IDLE therefore sees receive_enable==0 and does not re-trigger.
- receive_enable falling while in START, DATA or STOP (detector reset): abort to IDLE next edge. No pulses; data_out unchanged.
- receive_enable is ignored in DONE.
- Latency (defaults): let E0 be the edge at which IDLE samples receive_enable==1.
  - Start check at E0+8.
  - Data samples at E0+24, +40, …, +136.
  - Stop sample at E0+152.
  - char_received/data_valid high from E0+152 to E0+153.
  - busy is high from E0 to E0+153.
- data_in is sampled only on the sample edges listed above.
- A glitch between sample points has no effect.

Test Plan:
- Reset: hold reset=0 for 3 cycles while driving receive_enable=1 and toggling data_in → all outputs 0, state IDLE. Release reset → START entered on the next edge.
- Good frame: send 0xA5 (start 0, bits 1,0,1,0,0,1,0,1, stop 1; 16 clk/bit) with the sb_detect model attached → data_out=0xA5; data_valid, char_received, receive_enable and frame_error behave as follows:
  - data_valid and char_received pulse once, at E0+152;
  - receive_enable falls at the following negedge;
  - frame_error stays 0.
- False start: 3-cycle low glitch, then line high → at E0+8 go to DONE; char_received and frame_error pulse at E0+8; data_valid=0; data_out keeps its prior value.
- Bad stop: send 0x3C with stop bit 0 → frame_error and char_received pulse at E0+152; data_valid=0; data_out keeps its previous value (0xA5).
- Back-to-back: 0x00 then 0xFF, with the second start bit beginning immediately after the stop bit → two data_valid pulses; data_out=0x00 then 0xFF; no missed or extra char_received.
- Abort: drop receive_enable at E0+60 → busy=0 by E0+61; no char_received, data_valid or frame_error pulse; data_out unchanged.
